_shift_reg_en: RTL

_SHIFT_REG_EN -- requirements
Module: _shift_reg_en

---
 rtl/_shift_reg_en.sv | 106 ++++++++++
 1 files changed

// File: rtl/_shift_reg_en.sv
// Enabled universal shift register: load, shift, rotate, arithmetic shift and clear,
// with a saturating count of shifts performed since the last load or clear.
module _shift_reg_en #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             si_l,
  input  logic             si_r,
  output logic [WIDTH-1:0] q,
  output logic             so_l,
  output logic             so_r,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROTL  = 3'b100,
    OP_ROTR  = 3'b101,
    OP_ASR   = 3'b110,
    OP_CLEAR = 3'b111
  } op_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  op_e              op_dec;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next;
  logic             is_shift;
  logic [CNT_W-1:0] cnt_inc;

  assign op_dec = op_e'(op);

  // Counter saturates at WIDTH so full stays up through further shifts.
  assign cnt_inc = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);

  always_comb begin
    q_next   = q_r;
    is_shift = 1'b0;
    unique case (op_dec)
      OP_HOLD:  q_next = q_r;
      OP_LOAD:  q_next = d;
      OP_SHL: begin
        q_next   = {q_r[WIDTH-2:0], si_l};
        is_shift = 1'b1;
      end
      OP_SHR: begin
        q_next   = {si_r, q_r[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      OP_ROTL: begin
        q_next   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        is_shift = 1'b1;
      end
      OP_ROTR: begin
        q_next   = {q_r[0], q_r[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      OP_ASR: begin
        q_next   = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      OP_CLEAR: q_next = '0;
      default:  q_next = q_r;
    endcase
  end

  always_comb begin
    cnt_next = cnt_r;
    if (op_dec == OP_LOAD || op_dec == OP_CLEAR) begin
      cnt_next = '0;
    end else if (is_shift) begin
      cnt_next = cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r   <= '0;
      cnt_r <= '0;
    end else if (en) begin
      q_r   <= q_next;
      cnt_r <= cnt_next;
    end
  end

  // Status flags are decoded straight from the registers, no extra stage.
  assign q    = q_r;
  assign cnt  = cnt_r;
  assign so_l = q_r[WIDTH-1];
  assign so_r = q_r[0];
  assign full = (cnt_r == CNT_MAX);
  assign zero = (q_r == '0);

endmodule
